// File: rtl/scc68070_dma.sv
// rtl/scc68070_dma.sv - two-channel word DMA controller with CPU hold/idle bus arbitration
module scc68070_dma #(
    parameter int CLK_DIV_UNUSED = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_cs,
    input  logic [5:1]  reg_addr,
    input  logic        reg_write,
    input  logic        reg_uds,
    input  logic        reg_lds,
    input  logic [15:0] reg_wdata,
    output logic [15:0] reg_rdata,
    output logic        cpu_hold,
    input  logic        cpu_idle,
    output logic        bus_as,
    output logic        bus_uds,
    output logic        bus_lds,
    output logic        bus_write,
    output logic [23:1] bus_addr,
    output logic [15:0] bus_wdata,
    input  logic [15:0] bus_rdata,
    input  logic        bus_ack,
    input  logic [1:0]  dev_req,
    output logic [1:0]  dev_ack,
    input  logic [15:0] dev_rdata0,
    input  logic [15:0] dev_rdata1,
    output logic [15:0] dev_wdata,
    output logic [1:0]  irq
);
    localparam int unused_clk_div = CLK_DIV_UNUSED;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_BUS  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  r_state;
    logic        r_ch;
    logic        r_cur_dir;
    logic [1:0]  r_coc;
    logic [1:0]  r_act;
    logic [1:0]  r_dir;
    logic [1:0]  r_ie;
    logic [1:0]  r_abort;
    logic [15:0] r_mtc [2];
    logic [23:1] r_mar [2];
    logic [15:0] r_wdata;
    logic [15:0] r_rdata;

    logic        w_wr;
    logic        w_wch;
    logic [3:0]  w_widx;
    logic [1:0]  w_elig;
    logic        w_bus;
    logic [15:0] w_rdata;

    assign w_wr   = reg_cs & reg_write;
    assign w_wch  = reg_addr[5];
    assign w_widx = reg_addr[4:1];
    // A channel with an abort pending is no longer offered to the arbiter.
    assign w_elig = r_act & dev_req & ~r_abort;
    assign w_bus  = (r_state == S_BUS);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ch      <= 1'b0;
            r_cur_dir <= 1'b0;
            r_coc     <= '0;
            r_act     <= '0;
            r_dir     <= '0;
            r_ie      <= '0;
            r_abort   <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            for (int c = 0; c < 2; c++) begin
                r_mtc[c[0]] <= '0;
                r_mar[c[0]] <= '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (w_wr && (w_wch == c[0])) begin
                    case (w_widx)
                        4'd0: if (reg_uds && reg_wdata[15]) r_coc[c[0]] <= 1'b0;
                        4'd1: if (reg_uds) begin
                            r_dir[c[0]] <= reg_wdata[14];
                            r_ie[c[0]]  <= reg_wdata[13];
                            if (reg_wdata[15] && !r_act[c[0]]) begin
                                if (r_mtc[c[0]] != 16'd0) r_act[c[0]] <= 1'b1;
                                else                      r_coc[c[0]] <= 1'b1;
                            end
                            if (reg_wdata[12] && r_act[c[0]]) r_abort[c[0]] <= 1'b1;
                        end
                        4'd2: if (!r_act[c[0]]) begin
                            if (reg_uds) r_mtc[c[0]][15:8] <= reg_wdata[15:8];
                            if (reg_lds) r_mtc[c[0]][7:0]  <= reg_wdata[7:0];
                        end
                        4'd3: if (!r_act[c[0]] && reg_lds) r_mar[c[0]][23:16] <= reg_wdata[7:0];
                        4'd4: if (!r_act[c[0]]) begin
                            if (reg_uds) r_mar[c[0]][15:8] <= reg_wdata[15:8];
                            if (reg_lds) r_mar[c[0]][7:1]  <= reg_wdata[7:1];
                        end
                        default: ;
                    endcase
                end
                if ((r_state == S_IDLE) && r_abort[c[0]]) begin
                    r_act[c[0]]   <= 1'b0;
                    r_coc[c[0]]   <= 1'b1;
                    r_abort[c[0]] <= 1'b0;
                end
                // Placed after the register write so the word completion wins a same-cycle collision.
                if ((r_state == S_DONE) && (r_ch == c[0])) begin
                    r_mar[c[0]] <= r_mar[c[0]] + 23'd1;
                    r_mtc[c[0]] <= r_mtc[c[0]] - 16'd1;
                    if (r_mtc[c[0]] == 16'd1) begin
                        r_act[c[0]] <= 1'b0;
                        r_coc[c[0]] <= 1'b1;
                    end
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_elig[0]) begin
                        r_ch      <= 1'b0;
                        r_cur_dir <= r_dir[0];
                        r_state   <= S_HOLD;
                    end else if (w_elig[1]) begin
                        r_ch      <= 1'b1;
                        r_cur_dir <= r_dir[1];
                        r_state   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (cpu_idle) begin
                        r_wdata <= r_ch ? dev_rdata1 : dev_rdata0;
                        r_state <= S_BUS;
                    end
                end
                S_BUS: begin
                    if (bus_ack) begin
                        if (r_cur_dir) r_rdata <= bus_rdata;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_rdata = '0;
        if (reg_cs) begin
            case (w_widx)
                4'd0:    w_rdata = {r_coc[w_wch], 3'b000, r_act[w_wch], 11'd0};
                4'd1:    w_rdata = {1'b0, r_dir[w_wch], r_ie[w_wch], 13'd0};
                4'd2:    w_rdata = r_mtc[w_wch];
                4'd3:    w_rdata = {8'd0, r_mar[w_wch][23:16]};
                4'd4:    w_rdata = {r_mar[w_wch][15:1], 1'b0};
                default: w_rdata = '0;
            endcase
        end
    end

    assign reg_rdata = w_rdata;
    assign cpu_hold  = (r_state != S_IDLE);
    assign bus_as    = w_bus;
    assign bus_uds   = w_bus;
    assign bus_lds   = w_bus;
    assign bus_write = w_bus & ~r_cur_dir;
    assign bus_addr  = w_bus ? r_mar[r_ch] : '0;
    assign bus_wdata = r_wdata;
    assign dev_ack   = (r_state == S_DONE) ? (r_ch ? 2'b10 : 2'b01) : 2'b00;
    assign dev_wdata = r_rdata;
    assign irq       = r_coc & r_ie;
endmodule

// File: tb/tb_scc68070_dma.sv
// tb/tb_scc68070_dma.sv - self-checking bench for scc68070_dma with memory responder and transfer model
module tb_scc68070_dma;
    logic        clk = 1'b0;
    logic        reset;
    logic        reg_cs, reg_write, reg_uds, reg_lds;
    logic [5:1]  reg_addr;
    logic [15:0] reg_wdata, reg_rdata;
    logic        cpu_hold, cpu_idle;
    logic        bus_as, bus_uds, bus_lds, bus_write;
    logic [23:1] bus_addr;
    logic [15:0] bus_wdata, bus_rdata;
    logic        bus_ack;
    logic [1:0]  dev_req, dev_ack, irq;
    logic [15:0] dev_rdata0, dev_rdata1, dev_wdata;

    always #5 clk = ~clk;

    scc68070_dma #(.CLK_DIV_UNUSED(0)) dut (
        .clk(clk), .reset(reset), .reg_cs(reg_cs), .reg_addr(reg_addr), .reg_write(reg_write),
        .reg_uds(reg_uds), .reg_lds(reg_lds), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .cpu_hold(cpu_hold), .cpu_idle(cpu_idle), .bus_as(bus_as), .bus_uds(bus_uds),
        .bus_lds(bus_lds), .bus_write(bus_write), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .dev_req(dev_req), .dev_ack(dev_ack),
        .dev_rdata0(dev_rdata0), .dev_rdata1(dev_rdata1), .dev_wdata(dev_wdata), .irq(irq)
    );

    typedef struct { logic [22:0] addr; logic wr; logic [15:0] wdata; } cyc_t;
    typedef struct { int ch; logic [15:0] data; int cyc; } dack_t;

    cyc_t        cyc_q[$];
    dack_t       dack_q[$];
    logic [15:0] mem [int];
    int          errors = 0;
    int          checks = 0;
    int          ack_delay = 0;
    int          idle_mode = 0;
    int          cyc_n = 0;
    int          as_cnt = 0;
    int          hold_viol = 0;
    int          dack_bad = 0;

    function automatic logic [15:0] mem_rd(input logic [22:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return a[15:0] ^ 16'hC3C3;
    endfunction

    // Memory slave: acknowledges after ack_delay waiting cycles and logs every completed cycle.
    initial begin
        int cnt;
        cnt = 0;
        bus_ack = 1'b0;
        bus_rdata = 16'h0;
        forever begin
            @(negedge clk);
            if (bus_as === 1'b1 && bus_ack === 1'b0) begin
                if (cnt >= ack_delay) begin
                    bus_ack = 1'b1;
                    bus_rdata = mem_rd(bus_addr);
                    cyc_q.push_back('{addr: bus_addr, wr: bus_write, wdata: bus_wdata});
                    if (bus_write) mem[int'(bus_addr)] = bus_wdata;
                    cnt = 0;
                end else cnt++;
            end else begin
                bus_ack = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin
        cpu_idle = 1'b1;
        forever begin
            @(negedge clk);
            case (idle_mode)
                0: cpu_idle = 1'b1;
                1: cpu_idle = 1'b0;
                default: cpu_idle = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cyc_n++;
            if (bus_as === 1'b1) as_cnt++;
            if (bus_as === 1'b1 && cpu_hold !== 1'b1) hold_viol++;
            if (dev_ack == 2'b11) dack_bad++;
            if (dev_ack != 2'b00) dack_q.push_back('{ch: (dev_ack == 2'b01) ? 0 : (dev_ack == 2'b10) ? 1 : 3, data: dev_wdata, cyc: cyc_n});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic wr(input int ch, input int idx, input logic [15:0] d, input logic u = 1'b1, input logic l = 1'b1);
        @(negedge clk);
        reg_cs = 1'b1; reg_write = 1'b1; reg_addr = {ch[0], idx[3:0]};
        reg_uds = u; reg_lds = l; reg_wdata = d;
        @(negedge clk);
        reg_cs = 1'b0; reg_write = 1'b0; reg_uds = 1'b0; reg_lds = 1'b0;
    endtask

    task automatic rd(input int ch, input int idx, output logic [15:0] d);
        reg_cs = 1'b1; reg_write = 1'b0; reg_addr = {ch[0], idx[3:0]};
        #1 d = reg_rdata;
        reg_cs = 1'b0;
    endtask

    task automatic setup(input int ch, input logic [22:0] w, input logic [15:0] mtc, input logic dir, input logic ie);
        wr(ch, 0, 16'h8000);
        wr(ch, 2, mtc);
        wr(ch, 3, {8'h00, w[22:15]});
        wr(ch, 4, {w[14:0], 1'b0});
        wr(ch, 1, {1'b1, dir, ie, 13'd0});
    endtask

    task automatic wait_inactive(input int ch, input int budget, output bit ok);
        logic [15:0] s;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            rd(ch, 0, s);
            if (s[11] == 1'b0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        logic [15:0] d;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_as, bus_uds, bus_lds, bus_write, cpu_hold, dev_ack, irq, bus_addr, reg_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got as=%b hold=%b ack=%b irq=%b addr=%h rdata=%h, expected all 0",
                     bus_as, cpu_hold, dev_ack, irq, bus_addr, reg_rdata);
        end
        for (int ch = 0; ch < 2; ch++) begin
            for (int idx = 0; idx < 5; idx++) begin
                rd(ch, idx, d);
                checks++;
                if (d !== 16'h0) begin
                    errors++;
                    $display("FAIL reset_reg ch%0d idx%0d: got %h, expected 0000", ch, idx, d);
                end
            end
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_dev_to_mem;
        bit ok;
        logic [15:0] d;
        cyc_q.delete(); dack_q.delete();
        dev_rdata0 = 16'hA5A5;
        dev_req = 2'b01;
        setup(0, 23'h000800, 16'd3, 1'b0, 1'b1);
        wait_inactive(0, 100, ok);
        dev_req = 2'b00;
        checks++;
        if (!ok || cyc_q.size() != 3 || dack_q.size() != 3) begin
            errors++;
            $display("FAIL d2m_count: done=%0d cycles=%0d acks=%0d, expected 1/3/3", ok, cyc_q.size(), dack_q.size());
        end
        for (int i = 0; i < cyc_q.size() && i < 3; i++) begin
            checks++;
            if (cyc_q[i].addr !== 23'h000800 + 23'(i) || cyc_q[i].wr !== 1'b1 || cyc_q[i].wdata !== 16'hA5A5) begin
                errors++;
                $display("FAIL d2m_cycle%0d: got addr=%h wr=%b data=%h, expected addr=%h wr=1 data=a5a5",
                         i, cyc_q[i].addr, cyc_q[i].wr, cyc_q[i].wdata, 23'h000800 + 23'(i));
            end
        end
        for (int i = 0; i < dack_q.size(); i++) begin
            checks++;
            if (dack_q[i].ch != 0 || (i > 0 && dack_q[i].cyc - dack_q[i-1].cyc != 4)) begin
                errors++;
                $display("FAIL d2m_ack%0d: got ch=%0d spacing=%0d, expected ch=0 spacing=4",
                         i, dack_q[i].ch, (i > 0) ? dack_q[i].cyc - dack_q[i-1].cyc : 4);
            end
        end
        rd(0, 0, d);
        checks++;
        if (d !== 16'h8000 || irq !== 2'b01) begin
            errors++;
            $display("FAIL d2m_status: got status=%h irq=%b, expected 8000 / 01", d, irq);
        end
        wr(0, 0, 16'h8000);
        checks++;
        if (irq !== 2'b00) begin
            errors++;
            $display("FAIL d2m_irq_clear: got irq=%b, expected 00", irq);
        end
    endtask

    task automatic test_mem_to_dev;
        bit ok;
        logic [15:0] d;
        cyc_q.delete(); dack_q.delete();
        mem[int'(23'h004000)] = 16'h1234;
        dev_req = 2'b10;
        setup(1, 23'h004000, 16'd1, 1'b1, 1'b0);
        wait_inactive(1, 100, ok);
        dev_req = 2'b00;
        checks++;
        if (!ok || cyc_q.size() != 1 || dack_q.size() != 1) begin
            errors++;
            $display("FAIL m2d_count: done=%0d cycles=%0d acks=%0d, expected 1/1/1", ok, cyc_q.size(), dack_q.size());
        end else begin
            checks++;
            if (cyc_q[0].wr !== 1'b0 || cyc_q[0].addr !== 23'h004000 || dack_q[0].ch != 1 || dack_q[0].data !== 16'h1234) begin
                errors++;
                $display("FAIL m2d_data: got wr=%b addr=%h ackch=%0d data=%h, expected 0/004000/1/1234",
                         cyc_q[0].wr, cyc_q[0].addr, dack_q[0].ch, dack_q[0].data);
            end
        end
        rd(1, 0, d);
        checks++;
        if (d !== 16'h8000 || irq !== 2'b00) begin
            errors++;
            $display("FAIL m2d_status: got status=%h irq=%b, expected 8000 / 00", d, irq);
        end
        wr(1, 1, 16'h2000);
        checks++;
        if (irq !== 2'b10) begin
            errors++;
            $display("FAIL m2d_irq_enable: got irq=%b, expected 10", irq);
        end
        wr(1, 0, 16'h8000);
        wr(1, 1, 16'h0000);
    endtask

    task automatic test_priority;
        bit ok0, ok1;
        int as_before;
        cyc_q.delete(); dack_q.delete();
        dev_req = 2'b00;
        dev_rdata0 = 16'h1111;
        dev_rdata1 = 16'h2222;
        setup(0, 23'h000100, 16'd3, 1'b0, 1'b0);
        setup(1, 23'h000200, 16'd2, 1'b0, 1'b0);
        idle_mode = 1;
        @(negedge clk);
        as_before = as_cnt;
        dev_req = 2'b11;
        repeat (5) @(negedge clk);
        checks++;
        if (as_cnt != as_before || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL prio_hold: got as_cycles=%0d hold=%b, expected 0 / 1", as_cnt - as_before, cpu_hold);
        end
        idle_mode = 0;
        wait_inactive(0, 100, ok0);
        wait_inactive(1, 100, ok1);
        dev_req = 2'b00;
        checks++;
        if (!ok0 || !ok1 || cyc_q.size() != 5) begin
            errors++;
            $display("FAIL prio_count: done=%0d%0d cycles=%0d, expected 11 / 5", ok0, ok1, cyc_q.size());
        end
        for (int i = 0; i < cyc_q.size() && i < 5; i++) begin
            logic [22:0] ea;
            logic [15:0] ed;
            ea = (i < 3) ? 23'h000100 + 23'(i) : 23'h000200 + 23'(i - 3);
            ed = (i < 3) ? 16'h1111 : 16'h2222;
            checks++;
            if (cyc_q[i].addr !== ea || cyc_q[i].wdata !== ed) begin
                errors++;
                $display("FAIL prio_order%0d: got addr=%h data=%h, expected addr=%h data=%h",
                         i, cyc_q[i].addr, cyc_q[i].wdata, ea, ed);
            end
        end
        wr(0, 0, 16'h8000);
        wr(1, 0, 16'h8000);
    endtask

    task automatic test_wrap;
        bit ok;
        logic [15:0] m, h, l;
        cyc_q.delete(); dack_q.delete();
        dev_req = 2'b01;
        setup(0, 23'h7FFFFF, 16'd2, 1'b0, 1'b0);
        wait_inactive(0, 100, ok);
        dev_req = 2'b00;
        checks++;
        if (!ok || cyc_q.size() != 2 || cyc_q[0].addr !== 23'h7FFFFF || cyc_q[1].addr !== 23'h000000) begin
            errors++;
            $display("FAIL wrap_addr: done=%0d cycles=%0d first=%h second=%h, expected 1/2/7fffff/000000",
                     ok, cyc_q.size(), (cyc_q.size() > 0) ? cyc_q[0].addr : 23'h0, (cyc_q.size() > 1) ? cyc_q[1].addr : 23'h0);
        end
        rd(0, 2, m); rd(0, 3, h); rd(0, 4, l);
        checks++;
        if (m !== 16'h0 || h !== 16'h0 || l !== 16'h0002) begin
            errors++;
            $display("FAIL wrap_regs: got mtc=%h marh=%h marl=%h, expected 0000/0000/0002", m, h, l);
        end
        wr(0, 0, 16'h8000);
    endtask

    task automatic test_abort;
        bit ok, seen;
        logic [15:0] s, m;
        cyc_q.delete(); dack_q.delete();
        ack_delay = 4;
        dev_req = 2'b01;
        setup(0, 23'h000010, 16'd5, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus_as === 1'b1) begin seen = 1'b1; break; end
        end
        wr(0, 1, 16'h1000);
        wait_inactive(0, 100, ok);
        repeat (6) @(negedge clk);
        dev_req = 2'b00;
        ack_delay = 0;
        rd(0, 0, s); rd(0, 2, m);
        checks++;
        if (!seen || !ok || cyc_q.size() != 1 || dack_q.size() != 1) begin
            errors++;
            $display("FAIL abort_flow: bus_seen=%0d done=%0d cycles=%0d acks=%0d, expected 1/1/1/1",
                     seen, ok, cyc_q.size(), dack_q.size());
        end
        checks++;
        if (s !== 16'h8000 || m !== 16'd4) begin
            errors++;
            $display("FAIL abort_regs: got status=%h mtc=%h, expected 8000 / 0004", s, m);
        end
        wr(0, 0, 16'h8000);
    endtask

    task automatic test_start_zero;
        logic [15:0] s;
        int as_before;
        cyc_q.delete(); dack_q.delete();
        dev_req = 2'b10;
        wr(1, 0, 16'h8000);
        wr(1, 2, 16'h0000);
        as_before = as_cnt;
        wr(1, 1, 16'h8000);
        rd(1, 0, s);
        checks++;
        if (s !== 16'h8000) begin
            errors++;
            $display("FAIL start_zero_status: got %h, expected 8000", s);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (as_cnt != as_before || cpu_hold !== 1'b0 || dack_q.size() != 0) begin
            errors++;
            $display("FAIL start_zero_bus: got as_cycles=%0d hold=%b acks=%0d, expected 0/0/0",
                     as_cnt - as_before, cpu_hold, dack_q.size());
        end
        dev_req = 2'b00;
        wr(1, 0, 16'h8000);
    endtask

    task automatic test_reg_bytes;
        logic [15:0] a, b, c, e, s;
        wr(1, 2, 16'h12AB, 1'b0, 1'b1);
        rd(1, 2, a);
        wr(1, 2, 16'h3400, 1'b1, 1'b0);
        rd(1, 2, b);
        wr(1, 4, 16'hFFFF);
        rd(1, 4, c);
        wr(1, 7, 16'hFFFF);
        rd(1, 7, e);
        checks++;
        if (a !== 16'h00AB || b !== 16'h34AB || c !== 16'hFFFE || e !== 16'h0000) begin
            errors++;
            $display("FAIL reg_bytes: got lds=%h uds=%h marl=%h unused=%h, expected 00ab/34ab/fffe/0000", a, b, c, e);
        end
        dev_req = 2'b00;
        wr(1, 2, 16'h0002);
        wr(1, 1, 16'h8000);
        wr(1, 2, 16'h0077);
        rd(1, 2, a);
        rd(1, 0, s);
        checks++;
        if (a !== 16'h0002 || s !== 16'h0800) begin
            errors++;
            $display("FAIL reg_locked: got mtc=%h status=%h, expected 0002 / 0800", a, s);
        end
        wr(1, 1, 16'h1000);
        @(negedge clk);
        rd(1, 0, s);
        rd(1, 2, a);
        checks++;
        if (s !== 16'h8000 || a !== 16'h0002) begin
            errors++;
            $display("FAIL reg_abort_idle: got status=%h mtc=%h, expected 8000 / 0002", s, a);
        end
        wr(1, 0, 16'h8000);
    endtask

    task automatic test_random;
        for (int n = 0; n < 6; n++) begin
            int          ch, mtc;
            logic        dir, ie;
            logic [22:0] w;
            logic [15:0] data, m, h, l, s;
            cyc_t        exp_c[$];
            dack_t       exp_d[$];
            bit          ok;
            logic [22:0] fin;
            ch   = $urandom_range(0, 1);
            dir  = 1'($urandom_range(0, 1));
            ie   = 1'($urandom_range(0, 1));
            mtc  = $urandom_range(1, 6);
            w    = (n == 0) ? 23'h7FFFFD : 23'($urandom);
            data = 16'($urandom);
            ack_delay = $urandom_range(0, 2);
            for (int i = 0; i < mtc; i++) begin
                logic [22:0] a;
                a = w + 23'(i);
                exp_c.push_back('{addr: a, wr: !dir, wdata: data});
                exp_d.push_back('{ch: ch, data: mem_rd(a), cyc: 0});
            end
            fin = w + 23'(mtc);
            cyc_q.delete(); dack_q.delete();
            if (ch == 0) dev_rdata0 = data; else dev_rdata1 = data;
            idle_mode = 2;
            dev_req = (ch == 0) ? 2'b01 : 2'b10;
            setup(ch, w, 16'(mtc), dir, ie);
            wait_inactive(ch, 200, ok);
            dev_req = 2'b00;
            idle_mode = 0;
            checks++;
            if (!ok || cyc_q.size() != mtc || dack_q.size() != mtc) begin
                errors++;
                $display("FAIL rand%0d_count: done=%0d cycles=%0d acks=%0d, expected 1/%0d/%0d",
                         n, ok, cyc_q.size(), dack_q.size(), mtc, mtc);
            end
            for (int i = 0; i < mtc && i < cyc_q.size() && i < dack_q.size(); i++) begin
                checks++;
                if (cyc_q[i].addr !== exp_c[i].addr || cyc_q[i].wr !== exp_c[i].wr ||
                    (exp_c[i].wr && cyc_q[i].wdata !== exp_c[i].wdata) || dack_q[i].ch != ch ||
                    (dir && dack_q[i].data !== exp_d[i].data)) begin
                    errors++;
                    $display("FAIL rand%0d_word%0d: got addr=%h wr=%b wd=%h ch=%0d rd=%h, expected addr=%h wr=%b wd=%h ch=%0d rd=%h",
                             n, i, cyc_q[i].addr, cyc_q[i].wr, cyc_q[i].wdata, dack_q[i].ch, dack_q[i].data,
                             exp_c[i].addr, exp_c[i].wr, exp_c[i].wdata, ch, exp_d[i].data);
                end
            end
            rd(ch, 0, s); rd(ch, 2, m); rd(ch, 3, h); rd(ch, 4, l);
            checks++;
            if (s !== 16'h8000 || m !== 16'h0 || h !== {8'h00, fin[22:15]} || l !== {fin[14:0], 1'b0} || irq[ch] !== ie) begin
                errors++;
                $display("FAIL rand%0d_regs: got status=%h mtc=%h marh=%h marl=%h irq=%b, expected 8000/0000/%h/%h irq%0d=%b",
                         n, s, m, h, l, irq, {8'h00, fin[22:15]}, {fin[14:0], 1'b0}, ch, ie);
            end
            wr(ch, 0, 16'h8000);
        end
        ack_delay = 0;
    endtask

    task automatic test_reset_mid;
        bit seen;
        logic [15:0] s, m, l;
        cyc_q.delete(); dack_q.delete();
        ack_delay = 1000;
        dev_req = 2'b01;
        setup(0, 23'h000300, 16'd3, 1'b0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus_as === 1'b1) begin seen = 1'b1; break; end
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (!seen || {bus_as, bus_uds, bus_lds, bus_write, cpu_hold, dev_ack, irq} !== '0 || bus_addr !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: bus_seen=%0d as=%b hold=%b ack=%b irq=%b addr=%h, expected 1 and all 0",
                     seen, bus_as, cpu_hold, dev_ack, irq, bus_addr);
        end
        reset = 1'b0;
        dev_req = 2'b00;
        rd(0, 0, s); rd(0, 2, m); rd(0, 4, l);
        repeat (4) @(negedge clk);
        ack_delay = 0;
        checks++;
        if (s !== 16'h0 || m !== 16'h0 || l !== 16'h0 || dack_q.size() != 0 || cyc_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_regs: got status=%h mtc=%h marl=%h acks=%0d cycles=%0d, expected all 0",
                     s, m, l, dack_q.size(), cyc_q.size());
        end
    endtask

    task automatic test_protocol;
        checks++;
        if (hold_viol != 0 || dack_bad != 0) begin
            errors++;
            $display("FAIL protocol: got bus_without_hold=%0d double_ack=%0d, expected 0/0", hold_viol, dack_bad);
        end
    endtask

    initial begin
        reset = 1'b1;
        reg_cs = 1'b0; reg_write = 1'b0; reg_uds = 1'b0; reg_lds = 1'b0;
        reg_addr = '0; reg_wdata = '0;
        dev_req = 2'b00; dev_rdata0 = 16'h0; dev_rdata1 = 16'h0;
        test_reset();
        test_dev_to_mem();
        test_mem_to_dev();
        test_priority();
        test_wrap();
        test_abort();
        test_start_zero();
        test_reg_bytes();
        test_random();
        test_reset_mid();
        test_protocol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
